// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Sequencer state; the encodings are visible on state_o.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_INTERLOCK = 2'd1,
    ST_MEM_WAIT  = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_e;

  // Bit positions of each stage inside the packed enable vector.
  localparam int unsigned STG_F      = 0;
  localparam int unsigned STG_D      = 1;
  localparam int unsigned STG_E      = 2;
  localparam int unsigned STG_M      = 3;
  localparam int unsigned STG_W      = 4;
  localparam int unsigned NUM_STAGES = 5;

  // Control rules, numbered in priority order (lower number wins).
  typedef enum logic [2:0] {
    RULE_RESET        = 3'd1,
    RULE_MEM_FREEZE   = 3'd2,
    RULE_INTERLOCK    = 3'd3,
    RULE_REDIRECT     = 3'd4,
    RULE_FETCH_BUBBLE = 3'd5,
    RULE_RUN          = 3'd6
  } rule_e;

  // Enable patterns, indexed by the stage constants above.
  localparam logic [NUM_STAGES-1:0] EN_NONE = 5'b00000;
  localparam logic [NUM_STAGES-1:0] EN_ALL  = 5'b11111;
  localparam logic [NUM_STAGES-1:0] EN_EMW  = 5'b11100;
  localparam logic [NUM_STAGES-1:0] EN_NO_F = 5'b11110;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register: reset, then clear, then increment that holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: enables, bubbles, PC
// redirect, watchdogs and saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned MAX_INTERLOCK = 3,
  parameter int unsigned MEM_TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_stall,
  input  logic             calc_stall,
  input  logic             jump_takenD,
  input  logic             imem_valid,
  input  logic             dmem_busyM,
  input  logic             clr_cnt,
  output logic             enF,
  output logic             enD,
  output logic             enE,
  output logic             enM,
  output logic             enW,
  output logic             flushD,
  output logic             flushE,
  output logic             pc_redirect,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hang
);

  import pipe_ctrl_pkg::*;

  // Watchdog counters are sized to reach limit+1 and then hold there.
  localparam int unsigned IL_W = $clog2(MAX_INTERLOCK + 2);
  localparam int unsigned MW_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [IL_W-1:0] IL_LIMIT = IL_W'(MAX_INTERLOCK + 1);
  localparam logic [IL_W-1:0] IL_TRIP  = IL_W'(MAX_INTERLOCK);
  localparam logic [MW_W-1:0] MW_LIMIT = MW_W'(MEM_TIMEOUT + 1);
  localparam logic [MW_W-1:0] MW_TRIP  = MW_W'(MEM_TIMEOUT);

  state_e                  state_r;
  state_e                  state_nxt_s;
  rule_e                   rule_s;
  logic [NUM_STAGES-1:0]   en_s;
  logic                    flush_d_s;
  logic                    flush_e_s;
  logic                    redirect_s;
  logic [IL_W-1:0]         il_cnt_r;
  logic [MW_W-1:0]         mw_cnt_r;
  logic                    hang_r;
  logic                    stall_inc_s;
  logic                    flush_inc_s;

  // Priority decode of hazard requests into controls and the next state.
  always_comb begin
    rule_s      = RULE_RUN;
    en_s        = EN_ALL;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    redirect_s  = 1'b0;
    state_nxt_s = ST_RUN;
    if (!rst_n) begin
      rule_s      = RULE_RESET;
      en_s        = EN_NONE;
      flush_d_s   = 1'b1;
      flush_e_s   = 1'b1;
      state_nxt_s = ST_RUN;
    end else if (dmem_busyM) begin
      // Whole-pipe freeze; a pending jump is re-evaluated once it lifts.
      rule_s      = RULE_MEM_FREEZE;
      en_s        = EN_NONE;
      state_nxt_s = ST_MEM_WAIT;
    end else if (load_stall || calc_stall) begin
      rule_s      = RULE_INTERLOCK;
      en_s        = EN_EMW;
      flush_e_s   = 1'b1;
      state_nxt_s = ST_INTERLOCK;
    end else if (jump_takenD && (state_r != ST_REDIRECT)) begin
      // In REDIRECT the D slot is already a squashed bubble, so a jump
      // reported from it is stale and falls through.
      rule_s      = RULE_REDIRECT;
      en_s        = EN_ALL;
      flush_d_s   = 1'b1;
      redirect_s  = 1'b1;
      state_nxt_s = ST_REDIRECT;
    end else if (!imem_valid) begin
      rule_s      = RULE_FETCH_BUBBLE;
      en_s        = EN_NO_F;
      flush_d_s   = 1'b1;
      state_nxt_s = ST_RUN;
    end else begin
      rule_s      = RULE_RUN;
      en_s        = EN_ALL;
      state_nxt_s = ST_RUN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Consecutive-interlock watchdog counter, saturating at its limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      il_cnt_r <= {IL_W{1'b0}};
    end else if (rule_s == RULE_INTERLOCK) begin
      if (il_cnt_r != IL_LIMIT) begin
        il_cnt_r <= il_cnt_r + IL_W'(1);
      end else begin
        il_cnt_r <= il_cnt_r;
      end
    end else begin
      il_cnt_r <= {IL_W{1'b0}};
    end
  end

  // Consecutive-memory-wait watchdog counter, saturating at its limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mw_cnt_r <= {MW_W{1'b0}};
    end else if (rule_s == RULE_MEM_FREEZE) begin
      if (mw_cnt_r != MW_LIMIT) begin
        mw_cnt_r <= mw_cnt_r + MW_W'(1);
      end else begin
        mw_cnt_r <= mw_cnt_r;
      end
    end else begin
      mw_cnt_r <= {MW_W{1'b0}};
    end
  end

  // Sticky hang flag: set on the edge whose count reaches limit+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hang_r <= 1'b0;
    end else if ((rule_s == RULE_INTERLOCK) && (il_cnt_r >= IL_TRIP)) begin
      hang_r <= 1'b1;
    end else if ((rule_s == RULE_MEM_FREEZE) && (mw_cnt_r >= MW_TRIP)) begin
      hang_r <= 1'b1;
    end else begin
      hang_r <= hang_r;
    end
  end

  assign stall_inc_s = ~en_s[STG_F];
  assign flush_inc_s = flush_d_s | flush_e_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (stall_inc_s),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (flush_inc_s),
    .cnt   (flush_cnt)
  );

  assign enF         = en_s[STG_F];
  assign enD         = en_s[STG_D];
  assign enE         = en_s[STG_E];
  assign enM         = en_s[STG_M];
  assign enW         = en_s[STG_W];
  assign flushD      = flush_d_s;
  assign flushE      = flush_e_s;
  assign pc_redirect = redirect_s;
  assign state_o     = state_r;
  assign hang        = hang_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model. Two
// instances share the stimulus: default CNT_W and CNT_W=4 for saturation.
module tb_pipeline_ctrl;

  localparam int MAX_IL = 3;
  localparam int MEM_TO = 255;

  logic clk;
  logic rst_n, load_stall, calc_stall, jump_takenD, imem_valid, dmem_busyM, clr_cnt;
  logic enF, enD, enE, enM, enW, flushD, flushE, pc_redirect, hang;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt, flush_cnt;
  logic enF4, enD4, enE4, enM4, enW4, flushD4, flushE4, pc_redirect4, hang4;
  logic [1:0]  state_o4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_ctrl #(.CNT_W(32), .MAX_INTERLOCK(MAX_IL), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_stall(load_stall), .calc_stall(calc_stall),
    .jump_takenD(jump_takenD), .imem_valid(imem_valid), .dmem_busyM(dmem_busyM),
    .clr_cnt(clr_cnt), .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
    .flushD(flushD), .flushE(flushE), .pc_redirect(pc_redirect), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hang(hang));

  pipeline_ctrl #(.CNT_W(4), .MAX_INTERLOCK(MAX_IL), .MEM_TIMEOUT(MEM_TO)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_stall(load_stall), .calc_stall(calc_stall),
    .jump_takenD(jump_takenD), .imem_valid(imem_valid), .dmem_busyM(dmem_busyM),
    .clr_cnt(clr_cnt), .enF(enF4), .enD(enD4), .enE(enE4), .enM(enM4), .enW(enW4),
    .flushD(flushD4), .flushE(flushE4), .pc_redirect(pc_redirect4), .state_o(state_o4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .hang(hang4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_state = 0;      // 0 RUN, 1 INTERLOCK, 2 MEM_WAIT, 3 REDIRECT
  int     m_il = 0, m_mw = 0;
  bit     m_hang = 1'b0;
  longint m_stall = 0, m_flush = 0;

  function automatic longint clamp(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Compare on the falling edge, advance the model on the rising edge.
  always begin
    int     rule, n_state, n_il, n_mw;
    bit     n_hang;
    longint n_stall, n_flush;
    logic [4:0] e_en;   // {F,D,E,M,W}
    logic e_fd, e_fe, e_pr;
    @(negedge clk);
    e_fd = 1'b0; e_fe = 1'b0; e_pr = 1'b0; n_state = 0;
    if (!rst_n) begin
      rule = 1; e_en = 5'b00000; e_fd = 1'b1; e_fe = 1'b1;
    end else if (dmem_busyM) begin
      rule = 2; e_en = 5'b00000; n_state = 2;
    end else if (load_stall || calc_stall) begin
      rule = 3; e_en = 5'b00111; e_fe = 1'b1; n_state = 1;
    end else if (jump_takenD && m_state != 3) begin
      rule = 4; e_en = 5'b11111; e_fd = 1'b1; e_pr = 1'b1; n_state = 3;
    end else if (!imem_valid) begin
      rule = 5; e_en = 5'b01111; e_fd = 1'b1;
    end else begin
      rule = 6; e_en = 5'b11111;
    end
    check("en",       {enF, enD, enE, enM, enW}, e_en);
    check("flush",    {flushD, flushE}, {e_fd, e_fe});
    check("redirect", pc_redirect, e_pr);
    check("state",    state_o, m_state);
    check("hang",     hang, m_hang);
    check("stall_cnt",  stall_cnt, clamp(m_stall, 32));
    check("flush_cnt",  flush_cnt, clamp(m_flush, 32));
    check("en4",      {enF4, enD4, enE4, enM4, enW4, flushD4, flushE4, pc_redirect4},
                      {e_en, e_fd, e_fe, e_pr});
    check("state4",   state_o4, m_state);
    check("hang4",    hang4, m_hang);
    check("stall_cnt4", stall_cnt4, clamp(m_stall, 4));
    check("flush_cnt4", flush_cnt4, clamp(m_flush, 4));
    if (rule == 1) begin
      n_il = 0; n_mw = 0; n_hang = 1'b0; n_stall = 0; n_flush = 0;
    end else begin
      n_il   = (rule == 3) ? m_il + 1 : 0;
      n_mw   = (rule == 2) ? m_mw + 1 : 0;
      n_hang = m_hang || (n_il >= MAX_IL + 1) || (n_mw >= MEM_TO + 1);
      n_stall = clr_cnt ? 0 : m_stall + (e_en[4] ? 0 : 1);
      n_flush = clr_cnt ? 0 : m_flush + ((e_fd || e_fe) ? 1 : 0);
    end
    @(posedge clk);
    m_state = n_state; m_il = n_il; m_mw = n_mw; m_hang = n_hang;
    m_stall = n_stall; m_flush = n_flush;
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic ld, input logic calc, input logic jmp,
                        input logic iv, input logic busy, input logic clr);
    load_stall = ld; calc_stall = calc; jump_takenD = jmp;
    imem_valid = iv; dmem_busyM = busy; clr_cnt = clr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // Reset with all inputs high.
    repeat (2) begin
      @(negedge clk);
      check("rst_en", {enF, enD, enE, enM, enW}, 5'b00000);
      check("rst_flush", {flushD, flushE, pc_redirect}, 3'b110);
      next_cycle();
    end
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_state", state_o, 2'd0);
    check("post_rst_stall", stall_cnt, 32'd0);
    check("post_rst_flush", flush_cnt, 32'd0);
    check("post_rst_hang", hang, 1'b0);
    check("post_rst_en", {enF, enD, enE, enM, enW}, 5'b11111);
    next_cycle();

    // Load-use then dependent branch.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_en", {enF, enD, flushE}, 3'b001);
    next_cycle();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("calc_en", {enF, enD, flushE}, 3'b001);
    check("calc_state", state_o, 2'd1);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_stall_cnt", stall_cnt, 32'd2);
    check("lu_flush_cnt", flush_cnt, 32'd2);
    check("lu_hang", hang, 1'b0);
    next_cycle();

    // Taken jump held for two cycles.
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("jmp1", {flushD, pc_redirect}, 2'b11);
    next_cycle();
    @(negedge clk);
    check("jmp2_redirect", pc_redirect, 1'b0);
    check("jmp2_state", state_o, 2'd3);
    next_cycle();

    // Memory freeze with a pending jump.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("freeze_en", {enF, enD, enE, enM, enW}, 5'b00000);
      next_cycle();
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("unfreeze_redirect", pc_redirect, 1'b1);
    check("unfreeze_state", state_o, 2'd2);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("freeze_stall_cnt", stall_cnt, 32'd5);
    next_cycle();

    // Memory watchdog: 256 consecutive MEM_WAIT cycles.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == 256) check("wd_hang_before", hang, 1'b0);
      next_cycle();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("wd_hang_set", hang, 1'b1);
    check("wd_stall_cnt", stall_cnt, 32'd256);
    check("wd_stall_cnt4", stall_cnt4, 4'd15);
    next_cycle();
    @(negedge clk);
    check("wd_hang_sticky", hang, 1'b1);
    next_cycle();
    // Reset in the middle of a memory wait.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_state", state_o, 2'd0);
    check("midrst_hang", hang, 1'b0);
    check("midrst_cnts", {stall_cnt, flush_cnt}, 64'd0);
    next_cycle();

    // Saturation on the 4-bit instance, then clear during a stall.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("sat_stall_cnt4", stall_cnt4, 4'd15);
    check("sat_stall_cnt32", stall_cnt, 32'd20);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_stall_cnt4", stall_cnt4, 4'd0);
    check("clr_stall_cnt32", stall_cnt, 32'd0);
    next_cycle();

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      dmem_busyM  = ($urandom_range(0, 7) == 0);
      load_stall  = ($urandom_range(0, 5) == 0);
      calc_stall  = ($urandom_range(0, 5) == 0);
      jump_takenD = ($urandom_range(0, 2) == 0);
      imem_valid  = ($urandom_range(0, 4) != 0);
      clr_cnt     = ($urandom_range(0, 59) == 0);
      next_cycle();
    end
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
